// File: rtl/uncache_wbuf.sv
// Posted-write buffer between the uncache front end and the AXI uncached port.
// Stores are queued and acknowledged early; loads wait until every queued store has drained.
module uncache_wbuf #(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_en,
    input  logic [3:0]  up_wsel,
    input  logic [31:0] up_addr,
    input  logic [31:0] up_wdata,
    output logic [31:0] up_rdata,
    output logic        up_reload,
    output logic        dn_en,
    output logic [3:0]  dn_wen,
    output logic [31:0] dn_addr,
    output logic [31:0] dn_wdata,
    input  logic [31:0] dn_rdata,
    input  logic        dn_refresh,
    output logic        empty
);

    typedef enum logic [1:0] {D_IDLE, D_WRITE, D_READ} dstate_t;

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [31:0] mem_addr  [DEPTH];
    logic [3:0]  mem_wsel  [DEPTH];
    logic [31:0] mem_wdata [DEPTH];

    dstate_t       state;
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   cnt;
    logic          full;
    logic          push;
    logic          pop;
    logic          rd_go;

    // up_reload blocks acceptance so a request still held high is not taken twice
    assign full  = (cnt == FULL_CNT);
    assign push  = up_en && (up_wsel != 4'h0) && !full && !up_reload;
    assign pop   = (state == D_WRITE) && dn_refresh;
    assign rd_go = (cnt == '0) && up_en && (up_wsel == 4'h0) && !up_reload;
    assign empty = (cnt == '0) && (state == D_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wp]  <= up_addr;
            mem_wsel[wp]  <= up_wsel;
            mem_wdata[wp] <= up_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= D_IDLE;
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            up_reload <= 1'b0;
            up_rdata  <= 32'h0;
            dn_en     <= 1'b0;
            dn_wen    <= 4'h0;
            dn_addr   <= 32'h0;
            dn_wdata  <= 32'h0;
        end else begin
            up_reload <= push || ((state == D_READ) && dn_refresh);
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;

            case (state)
                D_IDLE: begin
                    if (cnt != '0) begin
                        state    <= D_WRITE;
                        dn_en    <= 1'b1;
                        dn_wen   <= mem_wsel[rp];
                        dn_addr  <= mem_addr[rp];
                        dn_wdata <= mem_wdata[rp];
                    end else if (rd_go) begin
                        state    <= D_READ;
                        dn_en    <= 1'b1;
                        dn_wen   <= 4'h0;
                        dn_addr  <= up_addr;
                        dn_wdata <= up_wdata;
                    end
                end
                D_WRITE: begin
                    if (dn_refresh) begin
                        state    <= D_IDLE;
                        dn_en    <= 1'b0;
                        dn_wen   <= 4'h0;
                        dn_addr  <= 32'h0;
                        dn_wdata <= 32'h0;
                    end
                end
                D_READ: begin
                    if (dn_refresh) begin
                        state    <= D_IDLE;
                        up_rdata <= dn_rdata;
                        dn_en    <= 1'b0;
                        dn_wen   <= 4'h0;
                        dn_addr  <= 32'h0;
                        dn_wdata <= 32'h0;
                    end
                end
                default: begin
                    state <= D_IDLE;
                    dn_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
